// File: rtl/data_mem_access.sv
// data_mem_access: memory-stage responder between the EX/MEM register and a
// variable-latency word-wide data memory. It aligns store lanes, runs a
// req/ack handshake, and returns extended load data to write-back while
// holding the pipeline for the duration of the access.
`timescale 1ns/1ps
module data_mem_access #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDRESS_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0]    wdata_in,
    input  logic [2:0]               store_en_in,
    input  logic                     load_en_in,
    input  logic [2:0]               load_type_in,
    output logic                     stall_out,
    output logic                     done_out,
    output logic [DATA_WIDTH-1:0]    load_data_out,
    output logic                     misalign_err_out,
    output logic                     mem_req_out,
    output logic                     mem_we_out,
    output logic [ADDRESS_WIDTH-3:0] mem_addr_out,
    output logic [3:0]               mem_be_out,
    output logic [DATA_WIDTH-1:0]    mem_wdata_out,
    input  logic                     mem_ack_in,
    input  logic [DATA_WIDTH-1:0]    mem_rdata_in
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Access size encoding shared by stores and loads.
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    state_t r_state;
    state_t w_next_state;

    logic                     r_mem_req;
    logic                     r_mem_we;
    logic [ADDRESS_WIDTH-3:0] r_mem_addr;
    logic [3:0]               r_mem_be;
    logic [DATA_WIDTH-1:0]    r_mem_wdata;
    logic                     r_done;
    logic [DATA_WIDTH-1:0]    r_load_data;
    logic                     r_misalign;
    logic [1:0]               r_off;
    logic [1:0]               r_size;
    logic                     r_unsigned;

    logic                  w_is_store;
    logic                  w_valid;
    logic                  w_misaligned;
    logic                  w_accept;
    logic [1:0]            w_off;
    logic [1:0]            w_size;
    logic                  w_unsigned;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;

    // Select the addressed lane of the read word and sign- or zero-extend it.
    function automatic logic [DATA_WIDTH-1:0] extend_load(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            off,
        input logic [1:0]            size,
        input logic                  uns
    );
        logic [DATA_WIDTH-1:0] lane;
        lane = word >> {off, 3'b000};
        case (size)
            SZ_B:    extend_load = uns ? {24'd0, lane[7:0]}
                                       : {{24{lane[7]}}, lane[7:0]};
            SZ_H:    extend_load = uns ? {16'd0, lane[15:0]}
                                       : {{16{lane[15]}}, lane[15:0]};
            default: extend_load = word;
        endcase
    endfunction

    assign w_off = addr_in[1:0];

    // Decode request kind, size, alignment and the lane-aligned store image.
    always_comb begin
        w_is_store = (store_en_in == 3'b001) || (store_en_in == 3'b010) ||
                     (store_en_in == 3'b011);
        w_valid    = w_is_store || load_en_in;
        w_unsigned = 1'b0;
        w_size     = SZ_W;
        w_be       = 4'b1111;
        w_wdata    = wdata_in;
        if (w_is_store) begin
            case (store_en_in)
                3'b001: begin
                    w_size  = SZ_B;
                    w_be    = 4'b0001 << w_off;
                    w_wdata = {4{wdata_in[7:0]}};
                end
                3'b010: begin
                    w_size  = SZ_H;
                    w_be    = 4'b0011 << w_off;
                    w_wdata = {2{wdata_in[15:0]}};
                end
                default: begin
                    w_size  = SZ_W;
                    w_be    = 4'b1111;
                    w_wdata = wdata_in;
                end
            endcase
        end else begin
            // Unknown funct3 codes fall back to a full word load.
            case (load_type_in)
                3'b000:  w_size = SZ_B;
                3'b001:  w_size = SZ_H;
                3'b100: begin
                    w_size     = SZ_B;
                    w_unsigned = 1'b1;
                end
                3'b101: begin
                    w_size     = SZ_H;
                    w_unsigned = 1'b1;
                end
                default: w_size = SZ_W;
            endcase
        end
        w_misaligned = ((w_size == SZ_H) && w_off[0]) ||
                       ((w_size == SZ_W) && (w_off != 2'b00));
        w_accept     = w_valid && !w_misaligned;
    end

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and the combinational pipeline hold.
    always_comb begin
        w_next_state = r_state;
        stall_out    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = WAIT;
                    stall_out    = 1'b1;
                end
            end
            WAIT: begin
                stall_out = 1'b1;
                if (mem_ack_in) begin
                    w_next_state = RESP;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Memory interface, response pulses and the held load result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
            r_load_data <= '0;
            r_misalign  <= 1'b0;
            r_off       <= 2'b00;
            r_size      <= SZ_W;
            r_unsigned  <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid && w_misaligned) begin
                        r_misalign <= 1'b1;
                    end else if (w_accept) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_is_store;
                        r_mem_addr  <= addr_in[ADDRESS_WIDTH-1:2];
                        r_mem_be    <= w_be;
                        r_mem_wdata <= w_wdata;
                        r_off       <= w_off;
                        r_size      <= w_size;
                        r_unsigned  <= w_unsigned;
                    end
                end
                WAIT: begin
                    if (mem_ack_in) begin
                        r_mem_req <= 1'b0;
                        r_done    <= 1'b1;
                        // Stores leave the last load result untouched.
                        if (!r_mem_we) begin
                            r_load_data <= extend_load(mem_rdata_in, r_off,
                                                       r_size, r_unsigned);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req_out      = r_mem_req;
    assign mem_we_out       = r_mem_we;
    assign mem_addr_out     = r_mem_addr;
    assign mem_be_out       = r_mem_be;
    assign mem_wdata_out    = r_mem_wdata;
    assign done_out         = r_done;
    assign load_data_out    = r_load_data;
    assign misalign_err_out = r_misalign;

endmodule
